// File: rtl/idecode_unit.sv
// Decode stage: buffers up to two fetched opcodes per cycle in an in-order
// queue and issues one decoded instruction per cycle to execution.
//
// Handshake: an instruction transfers to execution on any rising edge where
// dec_vld && exe_rdy. While dec_vld is high and exe_rdy is low, every dec_*
// output holds its value. dec_vld never depends combinationally on exe_rdy.
module idecode_unit #(
  parameter int IQ_DEPTH = 4,
  parameter int OPCODE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          opcode_vld,
  input  logic [OPCODE_W-1:0] opcode1,
  input  logic [OPCODE_W-1:0] opcode2,
  output logic                dec_busy,
  input  logic                flush,
  output logic                dec_vld,
  input  logic                exe_rdy,
  output logic [2:0]          dec_unit,
  output logic [5:0]          dec_op,
  output logic [4:0]          dec_vd,
  output logic [4:0]          dec_vs1,
  output logic [4:0]          dec_vs2,
  output logic [31:0]         dec_imm,
  output logic                dec_wr_en,
  output logic                err_overflow
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] UNIT_SCALAR  = 3'd0;
  localparam logic [2:0] UNIT_VARITH  = 3'd1;
  localparam logic [2:0] UNIT_VLOAD   = 3'd2;
  localparam logic [2:0] UNIT_VSTORE  = 3'd3;
  localparam logic [2:0] UNIT_BRANCH  = 3'd4;
  localparam logic [2:0] UNIT_ILLEGAL = 3'd7;

  logic [OPCODE_W-1:0] iq_mem [IQ_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       wr_ptr_p1;
  logic [CW-1:0]       count;

  logic                pop;
  logic [CW-1:0]       free_slots;
  logic [1:0]          n_valid;
  logic [1:0]          n_push;
  logic                drop;
  logic [OPCODE_W-1:0] first_op;
  logic [OPCODE_W-1:0] head;
  logic [5:0]          head_op;
  logic [2:0]          head_unit;

  // Pop/push accounting for this edge; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop        = !flush && (count != '0) && (!dec_vld || exe_rdy);
    free_slots = CW'(IQ_DEPTH) - count + CW'(pop);
    n_valid    = {1'b0, opcode_vld[0]} + {1'b0, opcode_vld[1]};
    n_push     = 2'd0;
    if (flush)
      n_push = 2'd0;
    else if (CW'(n_valid) <= free_slots)
      n_push = n_valid;
    else
      n_push = free_slots[1:0];
    drop      = !flush && (n_push != n_valid);
    first_op  = opcode_vld[0] ? opcode1 : opcode2;
    wr_ptr_p1 = wr_ptr + 1'b1;
  end

  // Decode the queue head so the result can be registered on a pop.
  always_comb begin
    head    = iq_mem[rd_ptr];
    head_op = head[31:26];
    if (head_op < 6'h10)      head_unit = UNIT_SCALAR;
    else if (head_op < 6'h20) head_unit = UNIT_VARITH;
    else if (head_op < 6'h24) head_unit = UNIT_VLOAD;
    else if (head_op < 6'h28) head_unit = UNIT_VSTORE;
    else if (head_op < 6'h30) head_unit = UNIT_BRANCH;
    else                      head_unit = UNIT_ILLEGAL;
  end

  // Queue storage; oldest valid opcode lands at wr_ptr, younger one after it.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) iq_mem[wr_ptr]    <= first_op;
    if (n_push == 2'd2) iq_mem[wr_ptr_p1] <= opcode2;
  end

  // Queue pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (drop) err_overflow <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(n_push);
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(n_push) - CW'(pop);
      end
    end
  end

  // Output register: loads the decoded head, holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_vld   <= 1'b0;
      dec_unit  <= '0;
      dec_op    <= '0;
      dec_vd    <= '0;
      dec_vs1   <= '0;
      dec_vs2   <= '0;
      dec_imm   <= '0;
      dec_wr_en <= 1'b0;
    end else if (flush) begin
      dec_vld <= 1'b0;
    end else if (pop) begin
      dec_vld   <= 1'b1;
      dec_unit  <= head_unit;
      dec_op    <= head_op;
      dec_vd    <= head[25:21];
      dec_vs1   <= head[20:16];
      dec_vs2   <= head[15:11];
      dec_imm   <= {{21{head[10]}}, head[10:0]};
      dec_wr_en <= (head_unit == UNIT_SCALAR) || (head_unit == UNIT_VARITH) ||
                   (head_unit == UNIT_VLOAD);
    end else if (exe_rdy) begin
      dec_vld <= 1'b0;
    end
  end

  // Back-pressure fetch when a dual push might not fit.
  assign dec_busy = (CW'(IQ_DEPTH) - count) < CW'(2);

endmodule
